flash_rom_fetch: RTL and testbench

FLASH_ROM_FETCH -- requirements
Module: flash_rom_fetch

---
 rtl/flash_rom_fetch.sv | 189 ++++++++++++++++++
 tb/tb_flash_rom_fetch.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rom_fetch.sv
// flash_rom_fetch: serves CPU PRG and PPU CHR byte reads from a serial-flash
// reader. Each port has a one-entry cache answered without touching flash;
// misses are arbitrated round-robin and fetched one at a time.
module flash_rom_fetch #(
    parameter logic [23:0] PRG_BASE = 24'h100000,
    parameter logic [23:0] CHR_BASE = 24'h140000,
    parameter int          PRG_AW   = 15,
    parameter int          CHR_AW   = 13
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_req,
    input  logic [13:0] ppu_addr,
    output logic        ppu_ack,
    output logic [7:0]  ppu_rdata,
    input  logic        flash_ready,
    input  logic [7:0]  flash_rdata,
    output logic        flash_read_en,
    output logic [23:0] flash_addr
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DATA} state_t;

    // Offsets are truncated to the used width so upper address bits mirror.
    localparam logic [15:0] PRG_MASK = 16'((32'd1 << PRG_AW) - 32'd1);
    localparam logic [15:0] CHR_MASK = 16'((32'd1 << CHR_AW) - 32'd1);

    state_t      state_q, state_d;
    logic        sel_q, sel_d;             // port owning the flash access (1 = PPU)
    logic        prio_q, prio_d;           // port that wins a tie (1 = PPU)
    logic        seen_low_q, seen_low_d;   // flash_ready has dropped since the strobe
    logic [23:0] flash_addr_q, flash_addr_d;
    logic [15:0] sel_off_q, sel_off_d;     // offset being fetched, for the cache fill

    logic [1:0]  req_vec;
    logic [1:0]  miss_vec;
    logic [1:0]  ack_vec;
    logic [15:0] off_arr   [2];
    logic [7:0]  rdata_arr [2];
    logic        go;
    logic        pick;
    logic        data_cyc;

    assign req_vec    = {ppu_req, cpu_req};
    assign off_arr[0] = cpu_addr & PRG_MASK;
    assign off_arr[1] = {2'b00, ppu_addr} & CHR_MASK;

    // State and shared datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            prio_q       <= 1'b0;
            seen_low_q   <= 1'b0;
            flash_addr_q <= 24'h000000;
            sel_off_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            prio_q       <= prio_d;
            seen_low_q   <= seen_low_d;
            flash_addr_q <= flash_addr_d;
            sel_off_q    <= sel_off_d;
        end
    end

    // Arbitration: start a fetch only when the reader is ready; tie goes to prio_q.
    always_comb begin
        go   = (state_q == IDLE) && flash_ready && (|miss_vec);
        pick = (&miss_vec) ? prio_q : miss_vec[1];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY:    if (data_cyc) state_d = DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: strobe in ISSUE; the data cycle is the first ready after a low.
    always_comb begin
        flash_read_en = 1'b0;
        data_cyc      = 1'b0;
        case (state_q)
            ISSUE:   flash_read_en = 1'b1;
            BUSY:    data_cyc = seen_low_q && flash_ready;
            default: ;
        endcase
    end

    // Shared datapath: latch the winner, its address and offset at selection time.
    always_comb begin
        sel_d        = sel_q;
        prio_d       = prio_q;
        flash_addr_d = flash_addr_q;
        sel_off_d    = sel_off_q;
        seen_low_d   = (state_q == BUSY) && (seen_low_q || !flash_ready);
        if (go) begin
            sel_d     = pick;
            prio_d    = !pick;
            sel_off_d = off_arr[pick];
            if (pick) flash_addr_d = CHR_BASE + {8'h00, off_arr[1]};
            else      flash_addr_d = PRG_BASE + {8'h00, off_arr[0]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_ID = (gi == 1);

            logic        inflight, hit, miss, capture;
            logic        cache_vld_q, cache_vld_d;
            logic [15:0] cache_off_q, cache_off_d;
            logic [7:0]  cache_dat_q, cache_dat_d;
            logic        done_q, done_d;   // acked; held until req is seen low
            logic        drop_q, drop_d;   // req went low while this port's fetch was in flight
            logic        ack_q, ack_d;
            logic [7:0]  rdata_q, rdata_d;

            // Per-port hit/miss detection, ack generation and cache fill.
            always_comb begin
                inflight    = (state_q != IDLE) && (sel_q == PORT_ID);
                hit         = req_vec[gi] && !done_q && !inflight && cache_vld_q
                              && (cache_off_q == off_arr[gi]);
                miss        = req_vec[gi] && !done_q && !inflight && !hit;
                capture     = data_cyc && (sel_q == PORT_ID);
                drop_d      = inflight && (drop_q || !req_vec[gi]);
                ack_d       = hit || (capture && !drop_q && req_vec[gi]);
                done_d      = req_vec[gi] && (done_q || ack_d);
                rdata_d     = rdata_q;
                cache_vld_d = cache_vld_q;
                cache_off_d = cache_off_q;
                cache_dat_d = cache_dat_q;
                if (hit) begin
                    rdata_d = cache_dat_q;
                end else if (ack_d) begin
                    rdata_d = flash_rdata;
                end
                if (capture) begin
                    cache_vld_d = 1'b1;
                    cache_off_d = sel_off_q;
                    cache_dat_d = flash_rdata;
                end
            end

            // Per-port registers.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cache_vld_q <= 1'b0;
                    cache_off_q <= 16'h0000;
                    cache_dat_q <= 8'h00;
                    done_q      <= 1'b0;
                    drop_q      <= 1'b0;
                    ack_q       <= 1'b0;
                    rdata_q     <= 8'h00;
                end else begin
                    cache_vld_q <= cache_vld_d;
                    cache_off_q <= cache_off_d;
                    cache_dat_q <= cache_dat_d;
                    done_q      <= done_d;
                    drop_q      <= drop_d;
                    ack_q       <= ack_d;
                    rdata_q     <= rdata_d;
                end
            end

            assign miss_vec[gi]  = miss;
            assign ack_vec[gi]   = ack_q;
            assign rdata_arr[gi] = rdata_q;
        end
    endgenerate

    assign cpu_ack    = ack_vec[0];
    assign ppu_ack    = ack_vec[1];
    assign cpu_rdata  = rdata_arr[0];
    assign ppu_rdata  = rdata_arr[1];
    assign flash_addr = flash_addr_q;

endmodule

// File: tb/tb_flash_rom_fetch.sv
// Testbench for flash_rom_fetch: flash reader model, scoreboard queues for
// read data and strobe addresses, directed steps in one initial block.
module tb_flash_rom_fetch;

    localparam int          LAT      = 3;
    localparam logic [23:0] PRG_BASE = 24'h100000;
    localparam logic [23:0] CHR_BASE = 24'h140000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        ppu_req;
    logic [13:0] ppu_addr;
    logic        ppu_ack;
    logic [7:0]  ppu_rdata;
    logic        flash_ready;
    logic [7:0]  flash_rdata;
    logic        flash_read_en;
    logic [23:0] flash_addr;

    // second instance for the address wrap case
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_ack;
    logic [7:0]  w_rdata;
    logic        w_preq;
    logic [13:0] w_paddr;
    logic        w_pack;
    logic [7:0]  w_prdata;
    logic        w_ready;
    logic [7:0]  w_fdata;
    logic        w_rd_en;
    logic [23:0] w_faddr;

    int tests = 0;
    int failed = 0;
    int n_strobe = 0;
    int cpu_ack_cnt = 0;
    int ppu_ack_cnt = 0;
    int rr_next = 0;

    logic [7:0]  cpu_exp  [$];
    logic [7:0]  ppu_exp  [$];
    logic [23:0] addr_exp [$];
    int          ack_order[$];

    always #5 clk = ~clk;

    flash_rom_fetch dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .flash_ready(flash_ready), .flash_rdata(flash_rdata),
        .flash_read_en(flash_read_en), .flash_addr(flash_addr)
    );

    flash_rom_fetch #(.PRG_BASE(24'hFFFFF0)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(w_req), .cpu_addr(w_addr), .cpu_ack(w_ack), .cpu_rdata(w_rdata),
        .ppu_req(w_preq), .ppu_addr(w_paddr), .ppu_ack(w_pack), .ppu_rdata(w_prdata),
        .flash_ready(w_ready), .flash_rdata(w_fdata),
        .flash_read_en(w_rd_en), .flash_addr(w_faddr)
    );

    function automatic logic [7:0] model_data(input logic [23:0] a);
        if (a == 24'h100123) return 8'h5A;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    function automatic logic [23:0] model_addr(input int port, input logic [15:0] a);
        logic [15:0] off;
        if (port == 0) begin
            off = a & 16'h7FFF;
            return PRG_BASE + {8'h00, off};
        end
        off = a & 16'h1FFF;
        return CHR_BASE + {8'h00, off};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // flash reader model: ready drops after a strobe, data cycle after LAT+1 low cycles
    logic        flash_hold;
    logic        fl_busy = 1'b0;
    int          fl_cnt = 0;
    logic        fl_dv = 1'b0;
    logic [23:0] fl_addr = 24'h0;

    always @(posedge clk) begin
        fl_dv <= 1'b0;
        if (flash_read_en) begin
            fl_busy <= 1'b1;
            fl_cnt  <= LAT;
            fl_addr <= flash_addr;
        end else if (fl_busy) begin
            if (fl_cnt == 0) begin
                fl_busy <= 1'b0;
                fl_dv   <= 1'b1;
            end else begin
                fl_cnt <= fl_cnt - 1;
            end
        end
    end

    assign flash_ready = !flash_hold && !fl_busy;
    assign flash_rdata = fl_dv ? model_data(fl_addr) : 8'hEE;

    // monitor: pop scoreboards on acks and strobes
    always @(negedge clk) begin
        if (cpu_ack) begin
            cpu_ack_cnt++;
            ack_order.push_back(0);
            if (cpu_exp.size() == 0) chk("cpu_ack_unexpected", cpu_ack, 0);
            else chk("cpu_rdata", cpu_rdata, cpu_exp.pop_front());
            $display("[TB] t=%0t cpu_ack rdata=%02h", $time, cpu_rdata);
        end
        if (ppu_ack) begin
            ppu_ack_cnt++;
            ack_order.push_back(1);
            if (ppu_exp.size() == 0) chk("ppu_ack_unexpected", ppu_ack, 0);
            else chk("ppu_rdata", ppu_rdata, ppu_exp.pop_front());
            $display("[TB] t=%0t ppu_ack rdata=%02h", $time, ppu_rdata);
        end
        if (flash_read_en) begin
            n_strobe++;
            if (addr_exp.size() == 0) chk("strobe_unexpected", flash_read_en, 0);
            else chk("flash_addr", flash_addr, addr_exp.pop_front());
            $display("[TB] t=%0t strobe addr=%06h", $time, flash_addr);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int port, input int limit, output int k);
        k = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            k++;
            if ((port == 0 && cpu_ack) || (port == 1 && ppu_ack)) return;
        end
        k = -1;
    endtask

    // single request on one port; miss expects a strobe and full latency
    task automatic do_req(input int port, input logic [15:0] a, input bit miss);
        logic [23:0] fa;
        int k;
        int s0;
        fa = model_addr(port, a);
        s0 = n_strobe;
        if (miss) begin
            addr_exp.push_back(fa);
            rr_next = 1 - port;
        end
        if (port == 0) begin
            cpu_exp.push_back(model_data(fa));
            cpu_addr = a;
            cpu_req  = 1'b1;
        end else begin
            ppu_exp.push_back(model_data(fa));
            ppu_addr = a[13:0];
            ppu_req  = 1'b1;
        end
        wait_ack(port, 40, k);
        chk(miss ? "miss_latency" : "hit_latency", k, miss ? LAT + 5 : 2);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        chk("strobe_count", n_strobe - s0, miss ? 1 : 0);
        tick(1);
    endtask

    // both ports request together; the bench predicts the round-robin winner
    task automatic contend(input logic [15:0] ca, input logic [15:0] pa);
        int winner;
        int c0;
        int p0;
        bit done;
        winner = rr_next;
        if (winner == 0) begin
            addr_exp.push_back(model_addr(0, ca));
            addr_exp.push_back(model_addr(1, pa));
        end else begin
            addr_exp.push_back(model_addr(1, pa));
            addr_exp.push_back(model_addr(0, ca));
        end
        rr_next = winner;
        cpu_exp.push_back(model_data(model_addr(0, ca)));
        ppu_exp.push_back(model_data(model_addr(1, pa)));
        ack_order.delete();
        c0 = cpu_ack_cnt;
        p0 = ppu_ack_cnt;
        cpu_addr = ca;
        ppu_addr = pa[13:0];
        cpu_req  = 1'b1;
        ppu_req  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (cpu_ack_cnt > c0) && (ppu_ack_cnt > p0);
        end
        tick(3);
        chk("contend_both_acked", done, 1);
        chk("contend_ack_count", ack_order.size(), 2);
        chk("rr_first", (ack_order.size() > 0) ? ack_order[0] : -1, winner);
        chk("rr_second", (ack_order.size() > 1) ? ack_order[1] : -1, 1 - winner);
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        tick(2);
    endtask

    initial begin
        int k;
        int a0;
        int s0;
        bit seen;

        reset_n    = 1'b0;
        cpu_req    = 1'b0;
        cpu_addr   = 16'h0;
        ppu_req    = 1'b0;
        ppu_addr   = 14'h0;
        flash_hold = 1'b1;
        w_req      = 1'b0;
        w_addr     = 16'h0;
        w_preq     = 1'b0;
        w_paddr    = 14'h0;
        w_ready    = 1'b1;
        w_fdata    = 8'h00;
        tick(3);

        // reset values
        chk("rst_flash_read_en", flash_read_en, 0);
        chk("rst_flash_addr", flash_addr, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ppu_ack", ppu_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ppu_rdata", ppu_rdata, 0);

        // flash initialisation: request held while ready is low for 40 cycles
        reset_n  = 1'b1;
        cpu_addr = 16'h8123;
        cpu_req  = 1'b1;
        cpu_exp.push_back(8'h5A);
        addr_exp.push_back(24'h100123);
        rr_next = 1;
        tick(40);
        chk("init_no_strobe", n_strobe, 0);
        flash_hold = 1'b0;
        tick(1);
        chk("init_strobe_first_cycle", flash_read_en, 1);
        wait_ack(0, 40, k);
        chk("init_ack_seen", (k > 0), 1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        tick(2);

        // cache hit, held high afterwards: exactly one ack, no strobe
        a0 = cpu_ack_cnt;
        s0 = n_strobe;
        cpu_exp.push_back(8'h5A);
        cpu_addr = 16'h8123;
        cpu_req  = 1'b1;
        wait_ack(0, 20, k);
        chk("hit_latency", k, 2);
        tick(6);
        chk("no_double_ack", cpu_ack_cnt - a0, 1);
        chk("hit_no_strobe", n_strobe - s0, 0);
        cpu_req = 1'b0;
        tick(2);

        // mirrored CPU miss, then hit through the mirror alias
        do_req(0, 16'hC456, 1'b1);
        do_req(0, 16'h4456, 1'b0);

        // PPU miss and hit
        do_req(1, 16'h0100, 1'b1);
        do_req(1, 16'h0100, 1'b0);

        // contention with round-robin, a single PPU miss, contention again
        contend(16'h0200, 16'h1FFF);
        do_req(1, 16'h0030, 1'b1);
        contend(16'h0300, 16'h0020);

        // request dropped while its fetch is in flight: no ack, cache still filled
        a0 = cpu_ack_cnt;
        addr_exp.push_back(model_addr(0, 16'h0400));
        rr_next  = 1;
        cpu_addr = 16'h0400;
        cpu_req  = 1'b1;
        tick(3);
        cpu_req = 1'b0;
        tick(LAT + 6);
        chk("drop_no_ack", cpu_ack_cnt - a0, 0);
        do_req(0, 16'h0400, 1'b0);

        // reset while BUSY: immediate reset values, cache invalidated
        addr_exp.push_back(model_addr(0, 16'h0500));
        cpu_addr = 16'h0500;
        cpu_req  = 1'b1;
        tick(3);
        reset_n = 1'b0;
        #1;
        chk("busy_rst_flash_read_en", flash_read_en, 0);
        chk("busy_rst_flash_addr", flash_addr, 0);
        chk("busy_rst_cpu_ack", cpu_ack, 0);
        chk("busy_rst_cpu_rdata", cpu_rdata, 0);
        cpu_req = 1'b0;
        rr_next = 0;
        tick(2);
        reset_n = 1'b1;
        tick(LAT + 4);
        do_req(0, 16'h0400, 1'b1);

        // address wrap modulo 2^24 on the second instance
        w_addr = 16'h0020;
        w_req  = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (w_rd_en) begin
                seen = 1'b1;
                chk("wrap_flash_addr", w_faddr, 24'h000010);
                $display("[TB] t=%0t wrap strobe addr=%06h", $time, w_faddr);
            end
        end
        chk("wrap_strobe_seen", seen, 1);
        tick(1);
        w_req = 1'b0;

        // every expectation consumed
        chk("cpu_scoreboard_empty", cpu_exp.size(), 0);
        chk("ppu_scoreboard_empty", ppu_exp.size(), 0);
        chk("addr_scoreboard_empty", addr_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
